// File: rtl/mac_unit_simd_if.sv
// Operand/result bus for mac_unit_simd; master drives beats, slave is the MAC.
interface mac_unit_simd_if #(
  parameter int unsigned N         = 16,
  parameter int unsigned SUM_WIDTH = 2 * N + 4,
  parameter int unsigned KW        = 8
);
  logic                 in_valid;
  logic                 mode_8b;
  logic [N-1:0]         xin;
  logic [N-1:0]         win;
  logic [SUM_WIDTH-1:0] acc_in;
  logic [KW-1:0]        k_len;
  logic [SUM_WIDTH-1:0] mac_out;
  logic                 out_valid;
  logic [N-1:0]         xout;
  logic                 xout_valid;
  logic                 busy;
  logic                 sat_flag;

  modport master (
    output in_valid, mode_8b, xin, win, acc_in, k_len,
    input  mac_out, out_valid, xout, xout_valid, busy, sat_flag
  );

  modport slave (
    input  in_valid, mode_8b, xin, win, acc_in, k_len,
    output mac_out, out_valid, xout, xout_valid, busy, sat_flag
  );
endinterface

// File: rtl/mac_unit_simd.sv
// Pipelined windowed MAC with full-width or dual-lane SIMD multiply.
// Optional saturating accumulation is enabled by defining MAC_SAT_EN.
module mac_unit_simd #(
  parameter int unsigned N         = 16,
  parameter int unsigned SUM_WIDTH = 2 * N + 4,
  parameter int unsigned KW        = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_unit_simd_if.slave   bus
);
  localparam int unsigned HALF = N / 2;

  // Window framing state
  logic [KW-1:0]        cnt_q;
  logic                 mode_q;
  logic [SUM_WIDTH-1:0] bias_q;

  // Stage 1: product register with window tags
  logic                 s1_vld;
  logic                 s1_first;
  logic                 s1_last;
  logic [SUM_WIDTH-1:0] s1_p;

  // Stage 2: running accumulator and emit flag
  logic [SUM_WIDTH-1:0] acc_q;
  logic                 sat_q;
  logic                 s2_emit;

  // Combinational helpers
  logic                 is_first_c;
  logic [KW-1:0]        cnt_nxt_c;
  logic                 is_last_c;
  logic                 mode_eff_c;
  logic [2*N-1:0]       xf_c, wf_c, prod_full_c;
  logic [N-1:0]         xh_c, wh_c, xl_c, wl_c, prod_hi_c, prod_lo_c;
  logic [N:0]           dot_c;
  logic [SUM_WIDTH-1:0] p_c;
  logic [SUM_WIDTH-1:0] base_c, sum_c, acc_nxt_c;
  logic                 sat_nxt_c;

  // Beat counter next value and first/last classification
  always_comb begin
    is_first_c = (cnt_q == '0);
    cnt_nxt_c  = cnt_q - KW'(1);
    if (is_first_c) begin
      cnt_nxt_c = (bus.k_len == '0) ? '0 : bus.k_len - KW'(1);
    end
    is_last_c  = (cnt_nxt_c == '0);
    mode_eff_c = is_first_c ? bus.mode_8b : mode_q;
  end

  // Product: full N x N, or sum of two signed N/2 lane products
  always_comb begin
    xf_c        = {{N{bus.xin[N-1]}}, bus.xin};
    wf_c        = {{N{bus.win[N-1]}}, bus.win};
    prod_full_c = xf_c * wf_c;
    xh_c        = {{HALF{bus.xin[N-1]}}, bus.xin[N-1:HALF]};
    wh_c        = {{HALF{bus.win[N-1]}}, bus.win[N-1:HALF]};
    xl_c        = {{HALF{bus.xin[HALF-1]}}, bus.xin[HALF-1:0]};
    wl_c        = {{HALF{bus.win[HALF-1]}}, bus.win[HALF-1:0]};
    prod_hi_c   = xh_c * wh_c;
    prod_lo_c   = xl_c * wl_c;
    dot_c       = {prod_hi_c[N-1], prod_hi_c} + {prod_lo_c[N-1], prod_lo_c};
    if (mode_eff_c) begin
      p_c = {{(SUM_WIDTH-N-1){dot_c[N]}}, dot_c};
    end else begin
      p_c = {{(SUM_WIDTH-2*N){prod_full_c[2*N-1]}}, prod_full_c};
    end
  end

  // Accumulate: first beat restarts from the latched bias
  always_comb begin
    base_c    = s1_first ? bias_q : acc_q;
    sum_c     = base_c + s1_p;
    acc_nxt_c = sum_c;
    sat_nxt_c = 1'b0;
`ifdef MAC_SAT_EN
    if ((base_c[SUM_WIDTH-1] == s1_p[SUM_WIDTH-1]) &&
        (sum_c[SUM_WIDTH-1] != base_c[SUM_WIDTH-1])) begin
      acc_nxt_c = base_c[SUM_WIDTH-1] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                      : {1'b0, {(SUM_WIDTH-1){1'b1}}};
      sat_nxt_c = 1'b1;
    end
    if (!s1_first) begin
      sat_nxt_c = sat_nxt_c | sat_q;
    end
`endif
  end

  // Window framing, stored mode/bias and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      bias_q   <= '0;
      bus.busy <= 1'b0;
    end else if (bus.in_valid) begin
      cnt_q    <= cnt_nxt_c;
      bus.busy <= !is_last_c;
      if (is_first_c) begin
        mode_q <= bus.mode_8b;
        bias_q <= bus.acc_in;
      end
    end
  end

  // Stage 1 register; contents hold across stalls, valid bit does not
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
    end else begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_first <= is_first_c;
        s1_last  <= is_last_c;
        s1_p     <= p_c;
      end
    end
  end

  // Stage 2 accumulator and result output register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      sat_q         <= 1'b0;
      s2_emit       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.mac_out   <= '0;
      bus.sat_flag  <= 1'b0;
    end else begin
      if (s1_vld) begin
        acc_q <= acc_nxt_c;
        sat_q <= sat_nxt_c;
      end
      s2_emit       <= s1_vld & s1_last;
      bus.out_valid <= s2_emit;
      if (s2_emit) begin
        bus.mac_out  <= acc_q;
        bus.sat_flag <= sat_q;
      end
    end
  end

  // Systolic forward of the activation stream
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.xout       <= '0;
      bus.xout_valid <= 1'b0;
    end else begin
      bus.xout_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.xout <= bus.xin;
      end
    end
  end
endmodule

// File: doc/mac_unit_simd.md
Name: mac_unit_simd

Overview:
Pipelined, windowed multiply-accumulate unit for the ECG CNN datapath. It is the parametrised successor of the single-cycle MAC.
- Runs in full N-bit mode or dual N/2-bit SIMD mode. SIMD mode computes a 2-term dot product per beat.
- Accumulates a programmable number of beats (kernel length) onto a bias, then emits one result with a valid pulse.
- Forwards xin one cycle later for systolic chaining.

Parameters:
N, 16, operand width; must be even; SIMD lanes are N/2 bits each.
SUM_WIDTH, 2*N+4, accumulator and result width, two's complement.
KW, 8, width of the kernel-length port and beat counter.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
mode_8b  input  1  0: N-bit multiply; 1: dual N/2-bit lanes; sampled on first beat of a window
xin  input  N  signed activation; in SIMD mode hi lane is [N-1:N/2], lo lane is [N/2-1:0]
win  input  N  signed weight, same lane split as xin
acc_in  input  SUM_WIDTH  signed bias; sampled on first beat of a window
k_len  input  KW  beats per window; sampled on first beat; 0 is treated as 1
mac_out  output  SUM_WIDTH  signed window result
out_valid  output  1  one-cycle pulse, mac_out updated this cycle
xout  output  N  xin delayed one cycle
xout_valid  output  1  in_valid delayed one cycle
busy  output  1  high while a window is open: first beat taken, last beat not yet taken
sat_flag  output  1  saturation indicator (see Optional Feature)

Behaviour:
- Reset: all outputs 0. Beat counter 0, pipeline valid bits cleared, stored mode/bias cleared.
- Reset mid-window: the partial window is discarded and no out_valid is issued.
- Window framing:
  - Counter == 0 means idle. The next in_valid beat is a first beat.
  - On a first beat: load counter with max(k_len,1)-1, latch mode_8b and acc_in, assert busy.
  - Each later valid beat decrements the counter.
  - A beat that leaves the counter at 0 is a last beat; busy drops after it.
  - k_len=1 makes one beat both first and last.
  - mode_8b, acc_in and k_len are ignored on non-first beats.
- Stall: in_valid low holds the counter, pipeline contents and accumulator. No accumulation occurs.
- Stage 1, registered on a valid beat:
  - Mode 0: p = xin*win, signed, sign-extended to SUM_WIDTH.
  - Mode 1: p = xin_hi*win_hi + xin_lo*win_lo, signed lanes, sign-extended.
  - p is tagged with first/last flags and a valid bit.
- Stage 2, on stage-1 valid:
  - First beat: acc = bias + p.
  - Otherwise: acc = acc + p.
  - Arithmetic is modulo 2^SUM_WIDTH.
  - On last beat: mac_out <= new acc and out_valid = 1 for one cycle.
- Latency: out_valid is asserted exactly 2 cycles after the clock edge capturing the last beat.
- mac_out holds its value until the next out_valid.
- Back-to-back windows: a last beat followed by a first beat on the next cycle is legal, with no bubble. The first flag overrides the accumulator, so there is no cross-window contamination. Consecutive out_valid pulses are possible.
- Systolic forward:
  - xout <= xin on in_valid, otherwise xout holds.
  - xout_valid <= in_valid every cycle.

Optional Feature:
Macro: MAC_SAT_EN.
- Defined:
  - Stage-2 addition saturates to [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1] on signed overflow.
  - sat_flag is sticky within a window, is cleared on each first beat, and is valid alongside out_valid.
- Not defined:
  - The accumulator wraps modulo 2^SUM_WIDTH.
  - sat_flag is tied 0.

Test Plan:
1. Mode 0, k_len=3, acc_in=10, beats (3,4),(-5,6),(100,-2) -> mac_out=-208, single out_valid pulse 2 cycles after the third beat, busy low afterwards.
2. Mode 1, k_len=1, acc_in=0, xin=16'h03FE, win=16'h0504 -> mac_out=7 (3*5 + -2*4).
3. Stall: k_len=2, acc_in=1, beats (2,2), then 3 idle cycles, then (3,3) -> no out_valid during the gap; mac_out=14. xout_valid mirrors in_valid delayed by 1.
4. Back-to-back k_len=1 windows: (7,7,acc 0) then (-1,1,acc 5) on consecutive cycles -> out_valid on two consecutive cycles, mac_out=49 then 4.
5. Reset mid-window: k_len=4, 2 beats, then rst for 1 cycle -> no out_valid, mac_out=0. Then k_len=1, (2,3,acc 0) -> mac_out=6.
6. Overflow: acc_in=2^35-1, (1,1), k_len=1 ->
   - MAC_SAT_EN not defined: mac_out=-2^35.
   - MAC_SAT_EN defined: mac_out=2^35-1 and sat_flag=1.
   - k_len=0 behaves as k_len=1.
